// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU op codes and state encoding.
package control_sequencer_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_OP_NONE = 5'b00000;
    localparam logic [4:0] ALU_OP_ADD  = 5'b00011;

    // Each instruction class owns its own T3.. states so the class is carried by the state itself.
    typedef enum logic [4:0] {
        S_RESET,
        S_T0, S_T1, S_T2,
        S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
        S_LDI_T3, S_LDI_T4, S_LDI_T5,
        S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
        S_HALT
    } state_e;

    function automatic logic isMemState(state_e s);
        return (s == S_T1) || (s == S_LD_T6) || (s == S_ST_T7);
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational instruction-class decode of the IR opcode field.
module control_sequencer_decode
    import control_sequencer_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic       isLd_o,
    output logic       isLdi_o,
    output logic       isSt_o,
    output logic       isHalt_o
);

    assign isLd_o   = (opcode_i == OP_LD);
    assign isLdi_o  = (opcode_i == OP_LDI);
    assign isSt_o   = (opcode_i == OP_ST);
    assign isHalt_o = (opcode_i == OP_HALT);

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit sequencing DataPath strobes for fetch, ld, ldi, st, nop and halt.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int         MEM_WAIT = 0,
    parameter logic [4:0] ALU_ADD  = ALU_OP_ADD
) (
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic [31:0] ir_i,
    input  logic        stop_i,
    output logic        run_o,
    output logic        pcOut_o,
    output logic        zlowOut_o,
    output logic        mdrOut_o,
    output logic        baOut_o,
    output logic        cOut_o,
    output logic        rOut_o,
    output logic        marIn_o,
    output logic        pcIn_o,
    output logic        mdrIn_o,
    output logic        irIn_o,
    output logic        yIn_o,
    output logic        zinLow_o,
    output logic        rIn_o,
    output logic        gra_o,
    output logic        grb_o,
    output logic        grc_o,
    output logic        incPc_o,
    output logic        read_o,
    output logic        write_o,
    output logic [4:0]  operation_o
);

    localparam int WaitW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   waitCnt_q, waitCnt_d;
    logic               stopReq_q, stopReq_d;
    logic               waitDone;
    logic               isLd, isLdi, isSt, isHalt;
    state_e             boundaryState;
    logic               unusedIrBits;

    control_sequencer_decode uDecode (
        .opcode_i (ir_i[31:27]),
        .isLd_o   (isLd),
        .isLdi_o  (isLdi),
        .isSt_o   (isSt),
        .isHalt_o (isHalt)
    );

    assign unusedIrBits  = ^ir_i[26:0];
    assign waitDone      = (waitCnt_q == '0);
    assign boundaryState = stopReq_q ? S_HALT : S_T0;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q   <= S_RESET;
            waitCnt_q <= '0;
            stopReq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            stopReq_q <= stopReq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stopReq_d = stopReq_q | stop_i;
        case (state_q)
            S_RESET:  state_d = S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     if (waitDone) state_d = S_T2;
            S_T2: begin
                if (isLd)        state_d = S_LD_T3;
                else if (isLdi)  state_d = S_LDI_T3;
                else if (isSt)   state_d = S_ST_T3;
                else if (isHalt) state_d = S_HALT;
                else             state_d = boundaryState;
            end
            S_LD_T3:  state_d = S_LD_T4;
            S_LD_T4:  state_d = S_LD_T5;
            S_LD_T5:  state_d = S_LD_T6;
            S_LD_T6:  if (waitDone) state_d = S_LD_T7;
            S_LD_T7:  state_d = boundaryState;
            S_LDI_T3: state_d = S_LDI_T4;
            S_LDI_T4: state_d = S_LDI_T5;
            S_LDI_T5: state_d = boundaryState;
            S_ST_T3:  state_d = S_ST_T4;
            S_ST_T4:  state_d = S_ST_T5;
            S_ST_T5:  state_d = S_ST_T6;
            S_ST_T6:  state_d = S_ST_T7;
            S_ST_T7:  if (waitDone) state_d = boundaryState;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RESET;
        endcase

        // Memory states reload the counter on entry and count down while held.
        waitCnt_d = waitCnt_q;
        if ((state_d != state_q) && isMemState(state_d)) begin
            waitCnt_d = WaitW'(MEM_WAIT);
        end else if (isMemState(state_q) && !waitDone) begin
            waitCnt_d = waitCnt_q - WaitW'(1);
        end
    end

    always_comb begin
        run_o       = (state_q != S_RESET) && (state_q != S_HALT);
        pcOut_o     = 1'b0;
        zlowOut_o   = 1'b0;
        mdrOut_o    = 1'b0;
        baOut_o     = 1'b0;
        cOut_o      = 1'b0;
        rOut_o      = 1'b0;
        marIn_o     = 1'b0;
        pcIn_o      = 1'b0;
        mdrIn_o     = 1'b0;
        irIn_o      = 1'b0;
        yIn_o       = 1'b0;
        zinLow_o    = 1'b0;
        rIn_o       = 1'b0;
        gra_o       = 1'b0;
        grb_o       = 1'b0;
        grc_o       = 1'b0;
        incPc_o     = 1'b0;
        read_o      = 1'b0;
        write_o     = 1'b0;
        operation_o = ALU_OP_NONE;
        case (state_q)
            S_T0: begin
                pcOut_o  = 1'b1;
                marIn_o  = 1'b1;
                incPc_o  = 1'b1;
                zinLow_o = 1'b1;
            end
            S_T1: begin
                zlowOut_o = 1'b1;
                pcIn_o    = 1'b1;
                read_o    = 1'b1;
                mdrIn_o   = 1'b1;
            end
            S_T2: begin
                mdrOut_o = 1'b1;
                irIn_o   = 1'b1;
            end
            S_LD_T3, S_LDI_T3, S_ST_T3: begin
                grb_o   = 1'b1;
                baOut_o = 1'b1;
                yIn_o   = 1'b1;
            end
            S_LD_T4, S_LDI_T4, S_ST_T4: begin
                cOut_o      = 1'b1;
                zinLow_o    = 1'b1;
                operation_o = ALU_ADD;
            end
            S_LD_T5, S_ST_T5: begin
                zlowOut_o = 1'b1;
                marIn_o   = 1'b1;
            end
            S_LD_T6: begin
                read_o  = 1'b1;
                mdrIn_o = 1'b1;
            end
            S_LD_T7: begin
                mdrOut_o = 1'b1;
                gra_o    = 1'b1;
                rIn_o    = 1'b1;
            end
            S_LDI_T5: begin
                zlowOut_o = 1'b1;
                gra_o     = 1'b1;
                rIn_o     = 1'b1;
            end
            S_ST_T6: begin
                gra_o   = 1'b1;
                rOut_o  = 1'b1;
                mdrIn_o = 1'b1;
            end
            S_ST_T7: write_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised and directed bench: two sequencers (MEM_WAIT 0 and 2) against a step-list reference model.
module tb_control_sequencer;

    localparam logic [24:0] M_RUN     = 25'd1 << 24;
    localparam logic [24:0] M_PCOUT   = 25'd1 << 23;
    localparam logic [24:0] M_ZLOWOUT = 25'd1 << 22;
    localparam logic [24:0] M_MDROUT  = 25'd1 << 21;
    localparam logic [24:0] M_BAOUT   = 25'd1 << 20;
    localparam logic [24:0] M_COUT    = 25'd1 << 19;
    localparam logic [24:0] M_ROUT    = 25'd1 << 18;
    localparam logic [24:0] M_MARIN   = 25'd1 << 17;
    localparam logic [24:0] M_PCIN    = 25'd1 << 16;
    localparam logic [24:0] M_MDRIN   = 25'd1 << 15;
    localparam logic [24:0] M_IRIN    = 25'd1 << 14;
    localparam logic [24:0] M_YIN     = 25'd1 << 13;
    localparam logic [24:0] M_ZINLOW  = 25'd1 << 12;
    localparam logic [24:0] M_RIN     = 25'd1 << 11;
    localparam logic [24:0] M_GRA     = 25'd1 << 10;
    localparam logic [24:0] M_GRB     = 25'd1 << 9;
    localparam logic [24:0] M_INCPC   = 25'd1 << 7;
    localparam logic [24:0] M_READ    = 25'd1 << 6;
    localparam logic [24:0] M_WRITE   = 25'd1 << 5;
    localparam logic [24:0] M_ADD     = 25'b00011;

    localparam logic [31:0] IR_LDI  = 32'h08800007;
    localparam logic [31:0] IR_LD   = 32'h00800010;
    localparam logic [31:0] IR_ST   = 32'h10800004;
    localparam logic [31:0] IR_HALT = 32'hD0000000;
    localparam logic [31:0] IR_NOP  = 32'hC8000000;
    localparam logic [31:0] IR_UNK  = 32'hF8000000;

    localparam int MD_RESET = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_HALT  = 2;

    logic        clk = 1'b0;
    logic        clear;
    logic        stop;
    logic [31:0] ir;
    logic [24:0] vec [2];

    int          checks = 0;
    int          errors = 0;

    int          mode    [2];
    bit          stopReq [2];
    bit          inFetch [2];
    logic [24:0] seqBuf  [2][16];
    int          seqLen  [2];
    int          seqPos  [2];
    logic [24:0] expVec  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gDut
        logic run, pcOut, zlowOut, mdrOut, baOut, cOut, rOut, marIn, pcIn, mdrIn;
        logic irIn, yIn, zinLow, rIn, gra, grb, grc, incPc, read, write;
        logic [4:0] operation;

        control_sequencer #(.MEM_WAIT(2 * g), .ALU_ADD(5'b00011)) dut (
            .clk_i       (clk),
            .clear_i     (clear),
            .ir_i        (ir),
            .stop_i      (stop),
            .run_o       (run),
            .pcOut_o     (pcOut),
            .zlowOut_o   (zlowOut),
            .mdrOut_o    (mdrOut),
            .baOut_o     (baOut),
            .cOut_o      (cOut),
            .rOut_o      (rOut),
            .marIn_o     (marIn),
            .pcIn_o      (pcIn),
            .mdrIn_o     (mdrIn),
            .irIn_o      (irIn),
            .yIn_o       (yIn),
            .zinLow_o    (zinLow),
            .rIn_o       (rIn),
            .gra_o       (gra),
            .grb_o       (grb),
            .grc_o       (grc),
            .incPc_o     (incPc),
            .read_o      (read),
            .write_o     (write),
            .operation_o (operation)
        );

        assign vec[g] = {run, pcOut, zlowOut, mdrOut, baOut, cOut, rOut, marIn, pcIn, mdrIn,
                         irIn, yIn, zinLow, rIn, gra, grb, grc, incPc, read, write, operation};
    end

    task automatic checkOutput(input string tag, input logic [24:0] observed, input logic [24:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: each instruction phase is a list of output words, memory steps repeated MEM_WAIT+1 times.
    task automatic pushStep(input int k, input logic [24:0] w, input bit mem);
        int reps = mem ? (2 * k + 1) : 1;
        for (int r = 0; r < reps; r++) begin
            seqBuf[k][seqLen[k]] = w | M_RUN;
            seqLen[k]++;
        end
    endtask

    task automatic loadSeq(input int k, input logic [4:0] op, input bit fetch);
        seqLen[k] = 0;
        seqPos[k] = 0;
        if (fetch) begin
            pushStep(k, M_PCOUT | M_MARIN | M_INCPC | M_ZINLOW, 0);
            pushStep(k, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 1);
            pushStep(k, M_MDROUT | M_IRIN, 0);
        end else begin
            pushStep(k, M_GRB | M_BAOUT | M_YIN, 0);
            pushStep(k, M_COUT | M_ZINLOW | M_ADD, 0);
            if (op == 5'b00001) begin
                pushStep(k, M_ZLOWOUT | M_GRA | M_RIN, 0);
            end else if (op == 5'b00000) begin
                pushStep(k, M_ZLOWOUT | M_MARIN, 0);
                pushStep(k, M_READ | M_MDRIN, 1);
                pushStep(k, M_MDROUT | M_GRA | M_RIN, 0);
            end else begin
                pushStep(k, M_ZLOWOUT | M_MARIN, 0);
                pushStep(k, M_GRA | M_ROUT | M_MDRIN, 0);
                pushStep(k, M_WRITE, 1);
            end
        end
        inFetch[k] = fetch;
        expVec[k]  = seqBuf[k][0];
        seqPos[k]  = 1;
    endtask

    task automatic endOfInstruction(input int k);
        if (stopReq[k]) begin
            mode[k]   = MD_HALT;
            expVec[k] = '0;
        end else begin
            loadSeq(k, 5'b0, 1);
        end
    endtask

    task automatic modelStep(input int k);
        logic [4:0] op;
        op = ir[31:27];
        if (clear) begin
            mode[k]    = MD_RESET;
            stopReq[k] = 0;
            expVec[k]  = '0;
            return;
        end
        if (mode[k] == MD_RESET) begin
            mode[k] = MD_RUN;
            loadSeq(k, 5'b0, 1);
        end else if (mode[k] == MD_HALT) begin
            expVec[k] = '0;
        end else if (seqPos[k] < seqLen[k]) begin
            expVec[k] = seqBuf[k][seqPos[k]];
            seqPos[k]++;
        end else if (inFetch[k] && (op == 5'b00000 || op == 5'b00001 || op == 5'b00010)) begin
            loadSeq(k, op, 0);
        end else if (inFetch[k] && op == 5'b11010) begin
            mode[k]   = MD_HALT;
            expVec[k] = '0;
        end else begin
            endOfInstruction(k);
        end
        stopReq[k] = stopReq[k] | stop;
    endtask

    task applyStimulus(input logic clr, input logic stp, input logic [31:0] instr, input string tag);
        clear = clr;
        stop  = stp;
        ir    = instr;
        @(posedge clk);
        #1;
        modelStep(0);
        modelStep(1);
        @(negedge clk);
        checkOutput({tag, "/w0"}, vec[0], expVec[0]);
        checkOutput({tag, "/w2"}, vec[1], expVec[1]);
    endtask

    int          quietCount;
    int          writeCount;
    logic [31:0] irTable [6];

    initial begin
        for (int k = 0; k < 2; k++) begin
            mode[k]    = MD_RESET;
            stopReq[k] = 0;
            inFetch[k] = 0;
            seqLen[k]  = 0;
            seqPos[k]  = 0;
            expVec[k]  = '0;
        end
        irTable[0] = IR_LD;
        irTable[1] = IR_LDI;
        irTable[2] = IR_ST;
        irTable[3] = IR_HALT;
        irTable[4] = IR_NOP;
        irTable[5] = IR_UNK;

        applyStimulus(1, 0, IR_LDI, "reset");
        applyStimulus(1, 0, IR_LDI, "reset");

        for (int i = 0; i < 10; i++) applyStimulus(0, 0, IR_LDI, "ldi");

        applyStimulus(1, 0, IR_LD, "ldClr");
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, IR_LD, "ld");

        applyStimulus(1, 0, IR_ST, "stClr");
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, IR_ST, "st");

        applyStimulus(1, 0, IR_HALT, "haltClr");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, IR_HALT, "haltEnter");
        quietCount = 0;
        for (int i = 0; i < 22; i++) begin
            applyStimulus(0, 0, IR_NOP, "halted");
            if (vec[0] != '0) quietCount++;
        end
        checkOutput("haltQuiet", 25'(quietCount), 25'd0);
        applyStimulus(1, 0, IR_NOP, "haltRestart");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, IR_NOP, "restart");

        applyStimulus(1, 0, IR_NOP, "nopClr");
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, IR_NOP, "nop");
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, IR_UNK, "unknown");

        applyStimulus(1, 0, IR_LD, "stopClr");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, IR_LD, "stopLd");
        applyStimulus(0, 1, IR_LD, "stopPulse");
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, IR_NOP, "stopDrain");

        applyStimulus(1, 0, IR_ST, "abortClr");
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, IR_ST, "abortSt");
        applyStimulus(1, 0, IR_NOP, "abortEdge");
        writeCount = (vec[0][5] ? 1 : 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, IR_NOP, "abortAfter");
            if (vec[0][5]) writeCount++;
        end
        checkOutput("noWriteAfterClear", 25'(writeCount), 25'd0);

        applyStimulus(1, 1, IR_LD, "clearAndStop");
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, IR_LD, "afterClearStop");

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                          irTable[$urandom_range(0, 5)], "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
